// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM status in, stage-register control, operand
// selects and event counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_RegWrite;
  logic             id_MemRead;
  logic [4:0]       id_WriteRegAddr;
  logic             id_jump;
  logic             ex_branch_taken;
  logic             mem_busy;

  logic             pc_hold;
  logic [1:0]       IFIDop;
  logic [1:0]       IDEXop;
  logic [1:0]       EXMEMop;
  logic [1:0]       busAMUX;
  logic [1:0]       busBMUX;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_RegWrite,
           id_MemRead, id_WriteRegAddr, id_jump, ex_branch_taken, mem_busy,
    input  pc_hold, IFIDop, IDEXop, EXMEMop, busAMUX, busBMUX,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_RegWrite,
           id_MemRead, id_WriteRegAddr, id_jump, ex_branch_taken, mem_busy,
    output pc_hold, IFIDop, IDEXop, EXMEMop, busAMUX, busBMUX,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM/WB scoreboard, load-use stall, branch/jump
// flush, memory-busy freeze, registered forwarding selects and saturating counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  typedef struct packed {
    logic       valid;
    logic       rw;
    logic       mr;
    logic [4:0] dest;
  } slot_t;

  typedef enum logic [1:0] {
    OP_ADV  = 2'd0,
    OP_BUB  = 2'd1,
    OP_HOLD = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    SEL_RF    = 2'd0,
    SEL_EXMEM = 2'd1,
    SEL_WB    = 2'd2
  } sel_e;

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0]       amux_q, amux_d, bmux_q, bmux_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  logic lu, take_br, take_lu, take_jmp, busy;

  function automatic logic writes(slot_t s, logic [4:0] r);
    return s.valid && s.rw && (s.dest == r) && (r != 5'd0);
  endfunction

  // WB is never a source: the register file writes before it reads.
  function automatic logic [1:0] fwd_sel(logic use_r, logic [4:0] r,
                                         slot_t ex, slot_t mem);
    if (!use_r)            return SEL_RF;
    else if (writes(ex, r))  return SEL_EXMEM;
    else if (writes(mem, r)) return SEL_WB;
    else                   return SEL_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c, logic inc);
    return (inc && !(&c)) ? c + CNT_W'(1) : c;
  endfunction

  always_comb begin
    lu = hz.id_valid && ex_q.mr &&
         ((hz.id_use_rs && writes(ex_q, hz.id_rs)) ||
          (hz.id_use_rt && writes(ex_q, hz.id_rt)));
    busy     = hz.mem_busy;
    take_br  = !busy && hz.ex_branch_taken;
    take_lu  = !busy && !hz.ex_branch_taken && lu;
    take_jmp = !busy && !hz.ex_branch_taken && !lu && hz.id_jump;
  end

  // Stage-register control; reset forces the quiet "advance" pattern.
  always_comb begin
    hz.pc_hold = 1'b0;
    hz.IFIDop  = OP_ADV;
    hz.IDEXop  = OP_ADV;
    hz.EXMEMop = OP_ADV;
    if (!reset) begin
      if (busy) begin
        hz.pc_hold = 1'b1;
        hz.IFIDop  = OP_HOLD;
        hz.IDEXop  = OP_HOLD;
        hz.EXMEMop = OP_HOLD;
      end else if (take_br) begin
        hz.IFIDop  = OP_BUB;
        hz.IDEXop  = OP_BUB;
      end else if (take_lu) begin
        hz.pc_hold = 1'b1;
        hz.IFIDop  = OP_HOLD;
        hz.IDEXop  = OP_BUB;
      end else if (take_jmp) begin
        hz.IFIDop  = OP_BUB;
      end
    end
  end

  always_comb begin
    ex_d   = ex_q;
    mem_d  = mem_q;
    wb_d   = wb_q;
    amux_d = amux_q;
    bmux_d = bmux_q;
    if (!busy) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (take_br || take_lu) begin
        ex_d   = '0;
        amux_d = SEL_RF;
        bmux_d = SEL_RF;
      end else begin
        ex_d   = '{valid: hz.id_valid, rw: hz.id_RegWrite,
                   mr: hz.id_MemRead, dest: hz.id_WriteRegAddr};
        amux_d = fwd_sel(hz.id_use_rs, hz.id_rs, ex_q, mem_q);
        bmux_d = fwd_sel(hz.id_use_rt, hz.id_rt, ex_q, mem_q);
      end
    end
    stall_d = sat_inc(stall_q, busy || take_lu);
    flush_d = sat_inc(flush_q, take_br || take_jmp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      amux_q  <= SEL_RF;
      bmux_q  <= SEL_RF;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      amux_q  <= amux_d;
      bmux_q  <= bmux_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.busAMUX   = amux_q;
  assign hz.busBMUX   = bmux_q;
  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the stall and flush event counters.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  the ID-stage instruction is real, not a bubble.
REQ-006 id_rs, id_rt  in  5 each  ID-stage source register numbers.
REQ-007 id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-008 id_RegWrite, id_MemRead  in  1 each  ID instruction writes a register / is a load.
REQ-009 id_WriteRegAddr  in  5  ID instruction destination register.
REQ-010 id_jump  in  1  ID stage resolved an unconditional jump.
REQ-011 ex_branch_taken  in  1  EX stage resolved a taken branch.
REQ-012 mem_busy  in  1  data memory cannot complete this cycle.
REQ-013 pc_hold  out  1  PC keeps its value at the next edge.
REQ-014 IFIDop, IDEXop, EXMEMop  out  2 each  stage-register control: 0 advance, 1 bubble/flush, 2 hold.
REQ-015 busAMUX, busBMUX  out  2 each  EX operand select: 0 register file, 1 EX/MEM ALU result, 2 WB write data; registered.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  event counters.

Function
REQ-017 Scoreboard: three internal slots, EXs, MEMs and WBs; each holds {valid, RegWrite, MemRead, dest[4:0]} and mirrors the instruction in that stage.
REQ-018 A slot SHALL count as a writer of register r only when valid=1, RegWrite=1, dest=r and r!=0.
REQ-019 Load-use hazard (LU): id_valid=1, EXs.MemRead=1, and EXs writes id_rs with id_use_rs=1 or writes id_rt with id_use_rt=1.
REQ-020 Control priority SHALL be mem_busy > ex_branch_taken > LU > id_jump > normal; the control outputs are combinational from the inputs and the scoreboard.
REQ-021 On mem_busy: pc_hold=1; IFIDop, IDEXop and EXMEMop all = 2; the scoreboard and the busAMUX/busBMUX registers hold.
REQ-022 On ex_branch_taken: pc_hold=0; IFIDop=1; IDEXop=1; EXMEMop=0.
REQ-023 On LU: pc_hold=1; IFIDop=2; IDEXop=1; EXMEMop=0.
REQ-024 On id_jump: pc_hold=0; IFIDop=1; IDEXop=0; EXMEMop=0.
REQ-025 Normal case: pc_hold=0 and all ops=0.
REQ-026 Scoreboard advance on every edge without mem_busy: WBs<=MEMs and MEMs<=EXs.
REQ-027 On the same edge, EXs SHALL load a bubble (valid=0) under branch or LU; otherwise it loads {id_valid, id_RegWrite, id_MemRead, id_WriteRegAddr}.
REQ-028 busAMUX on an advancing edge where the ID instruction enters EX SHALL be computed from the pre-edge scoreboard:
- 1 if EXs writes id_rs;
- else 2 if MEMs writes id_rs;
- else 0.
- EXs takes precedence when both EXs and MEMs match.
REQ-029 busBMUX SHALL follow the same rule as busAMUX, using id_rt.
REQ-030 When a bubble enters EX (branch or LU), busAMUX and busBMUX SHALL load 0.
REQ-031 id_use_rs=0 forces busAMUX to 0; id_use_rt=0 forces busBMUX to 0.
REQ-032 A writer in WBs is not forwarded; the register file writes before it reads.
REQ-033 stall_cnt SHALL increment by 1 on each edge where LU or mem_busy is asserted.
REQ-034 flush_cnt SHALL increment by 1 on each edge where ex_branch_taken or id_jump takes effect per REQ-020.
REQ-035 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-036 On an LU edge, the load moves to MEMs. On the next cycle LU is false, and the consumer enters EX with select 2.
REQ-037 An LU condition that coincides with ex_branch_taken SHALL be discarded; the branch is taken and flush_cnt increments, stall_cnt does not.

Reset
REQ-038 While reset=1 at a rising edge, all scoreboard slots SHALL become valid=0, busAMUX=busBMUX=0, and stall_cnt=flush_cnt=0.
REQ-039 Reset SHALL override every other input, including mid-stall and mid-mem_busy.
REQ-040 While reset=1, outputs SHALL be pc_hold=0 and all ops=0.
REQ-041 On the first cycle after reset, no forwarding or LU SHALL occur.

Verification
REQ-042 Back-to-back forwarding: add $3 into EX, then ID reads rs=$3 -> next cycle busAMUX=1; one more independent instruction later -> busAMUX=2.
REQ-043 Load-use: lw $5 in EX, ID reads rt=$5 -> pc_hold=1, IFIDop=2, IDEXop=1, stall_cnt 0->1; next cycle all ops=0; consumer reaches EX with busBMUX=2.
REQ-044 $0 destination: EXs dest=0 RegWrite=1, ID reads $0 -> busAMUX=0, no LU.
REQ-045 Priority collision: ex_branch_taken=1 with LU and mem_busy=0 -> IFIDop=1, IDEXop=1, pc_hold=0, flush_cnt+1, stall_cnt unchanged; add mem_busy=1 -> all ops=2, stall_cnt+1 only.
REQ-046 Saturation and reset: CNT_W=2, four LU events -> stall_cnt=3; assert reset during mem_busy=1 -> next cycle counters=0, ops=0, busAMUX=busBMUX=0.
